rsa_two_power_mod: RTL and testbench



---
 rtl/rsa_two_power_mod_pkg.sv | 27 ++
 rtl/rsa_two_power_mod_double_step.sv | 32 +++
 rtl/rsa_two_power_mod.sv | 111 +++++++++++
 tb/tb_rsa_two_power_mod.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_two_power_mod_pkg.sv
// Shared types and constants for the 2^power mod modulus block.
//
// Contents:
//   DEFAULT_MOD_WIDTH   - default modulus/result width in bits
//   DEFAULT_POWER_WIDTH - default exponent field width in bits
//   RSATwoPowerModIn    - request payload {power, modulus}
//   RSATwoPowerModOut   - result payload (MOD_WIDTH-bit key type)
//   two_pow_state_e     - controller FSM states
package rsa_two_power_mod_pkg;

  localparam int unsigned DEFAULT_MOD_WIDTH   = 256;
  localparam int unsigned DEFAULT_POWER_WIDTH = 10;

  typedef logic [DEFAULT_MOD_WIDTH-1:0] RSATwoPowerModOut;

  typedef struct packed {
    logic [DEFAULT_POWER_WIDTH-1:0] power;
    logic [DEFAULT_MOD_WIDTH-1:0]   modulus;
  } RSATwoPowerModIn;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } two_pow_state_e;

endpackage

// File: rtl/rsa_two_power_mod_double_step.sv
// One modular doubling step: reduced = (2 * result) mod modulus.
//
// Ports:
//   result  - current value, MOD_WIDTH+1 bits, must satisfy result < modulus
//   modulus - modulus, MOD_WIDTH bits
//   reduced - doubled value reduced once against modulus, MOD_WIDTH+1 bits
//
// Because result < modulus, 2*result < 2*modulus, so a single conditional
// subtraction fully reduces. With modulus 0 or 1 a zero input stays zero.
module rsa_mod_double_step #(
  parameter int unsigned MOD_WIDTH = 256
) (
  input  logic [MOD_WIDTH:0]   result,
  input  logic [MOD_WIDTH-1:0] modulus,
  output logic [MOD_WIDTH:0]   reduced
);

  logic [MOD_WIDTH:0] doubled;
  logic [MOD_WIDTH:0] modulus_ext;

  always_comb begin
    doubled     = result << 1;
    modulus_ext = {1'b0, modulus};
    // >= (not >): a doubled value equal to the modulus must reduce to 0.
    if (doubled >= modulus_ext) begin
      reduced = doubled - modulus_ext;
    end else begin
      reduced = doubled;
    end
  end

endmodule

// File: rtl/rsa_two_power_mod.sv
// Computes 2^power mod modulus by repeated modular doubling, one doubling per
// cycle. Used to produce the Montgomery constant R^2 mod N for the multiplier.
//
// Ports:
//   clk, rst - clock, asynchronous active-low reset
//   i_valid  - request valid
//   i_ready  - block idle and able to accept (combinational, high in reset)
//   i_in     - request {power, modulus}, sampled only on the accept edge
//   o_valid  - result valid, held until o_ready
//   o_ready  - consumer accepts result
//   o_out    - 2^power mod modulus, zero whenever o_valid is low
//
// MOD_WIDTH and POWER_WIDTH must match the package defaults, since the
// payload types are fixed in the package.
module rsa_two_power_mod
  import rsa_two_power_mod_pkg::*;
#(
  parameter int unsigned MOD_WIDTH   = DEFAULT_MOD_WIDTH,
  parameter int unsigned POWER_WIDTH = DEFAULT_POWER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  RSATwoPowerModIn  i_in,
  output logic             o_valid,
  input  logic             o_ready,
  output RSATwoPowerModOut o_out
);

  two_pow_state_e state_q, state_d;

  logic [MOD_WIDTH-1:0]   modulus_q, modulus_d;
  logic [POWER_WIDTH-1:0] power_q, power_d;
  logic [POWER_WIDTH-1:0] counter_q, counter_d;
  // One spare bit so the doubled value never overflows before reduction.
  logic [MOD_WIDTH:0]     result_q, result_d;
  logic [MOD_WIDTH:0]     step_result;

  rsa_mod_double_step #(
    .MOD_WIDTH (MOD_WIDTH)
  ) u_double_step (
    .result  (result_q),
    .modulus (modulus_q),
    .reduced (step_result)
  );

  always_comb begin
    state_d   = state_q;
    modulus_d = modulus_q;
    power_d   = power_q;
    counter_d = counter_q;
    result_d  = result_q;
    i_ready   = (state_q == StIdle);
    o_valid   = 1'b0;
    o_out     = '0;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          modulus_d = i_in.modulus;
          power_d   = i_in.power;
          counter_d = '0;
          // 2^0 mod m is 1, except modulus 0 or 1 where everything is 0.
          result_d    = '0;
          result_d[0] = (i_in.modulus[MOD_WIDTH-1:1] != '0);
          state_d     = (i_in.power != '0) ? StBusy : StDone;
        end
      end

      StBusy: begin
        result_d  = step_result;
        counter_d = counter_q + 1'b1;
        // Terminate against the latched power so the counter never wraps,
        // even at the maximum power.
        if (counter_q == power_q - 1'b1) begin
          state_d = StDone;
        end
      end

      StDone: begin
        o_valid = 1'b1;
        o_out   = result_q[MOD_WIDTH-1:0];
        if (o_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      modulus_q <= '0;
      power_q   <= '0;
      counter_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      modulus_q <= modulus_d;
      power_q   <= power_d;
      counter_q <= counter_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_rsa_two_power_mod.sv
// Directed bench for rsa_two_power_mod. Latency is counted with the accept
// cycle as cycle 1, so a power-p job shows o_valid in cycle p+1.
module tb_rsa_two_power_mod;
  import rsa_two_power_mod_pkg::*;

  localparam int unsigned MW = DEFAULT_MOD_WIDTH;
  localparam int unsigned PW = DEFAULT_POWER_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             i_ready;
  RSATwoPowerModIn  i_in;
  logic             o_valid;
  logic             o_ready;
  RSATwoPowerModOut o_out;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  rsa_two_power_mod #(
    .MOD_WIDTH   (MW),
    .POWER_WIDTH (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_in    (i_in),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_out   (o_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one job with o_ready held high; returns result, latency and the
  // cycle number of the accept edge. Leaves time #1 after the handshake edge.
  task automatic do_job(input logic [MW-1:0] modulus, input logic [PW-1:0] power,
                        output logic [MW-1:0] result, output int lat,
                        output int acc_cyc, output bit timed_out);
    @(negedge clk);
    i_in.modulus = modulus;
    i_in.power   = power;
    i_valid      = 1'b1;
    o_ready      = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    i_valid   = 1'b0;
    lat       = 1;
    timed_out = 1'b0;
    while (!o_valid) begin
      if (lat > 2000) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    result = o_out;
    if (!timed_out) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    i_in    = '0;
    #12;
    vectors += 3;
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_i_ready: got %b want 1", i_ready);
    end
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_o_valid: got %b want 0", o_valid);
    end
    if (o_out !== '0) begin
      miscompares++; $display("FAIL reset_o_out: got %0d want 0", o_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors += 2;
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_i_ready: got %b want 1", i_ready);
    end
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_o_valid: got %b want 0", o_valid);
    end
  endtask

  task automatic test_basic();
    logic [MW-1:0] got;
    int lat, acc;
    bit to;
    do_job(13, 4, got, lat, acc, to);
    vectors += 5;
    if (to) begin
      miscompares++; $display("FAIL basic_timeout: got no o_valid want o_valid");
    end
    if (got !== 3) begin
      miscompares++; $display("FAIL basic_out: got %0d want 3", got);
    end
    if (lat != 5) begin
      miscompares++; $display("FAIL basic_latency: got %0d want 5", lat);
    end
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL basic_i_ready_after: got %b want 1", i_ready);
    end
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_o_valid_after: got %b want 0", o_valid);
    end
  endtask

  task automatic test_edge_cases();
    logic [MW-1:0] got;
    int lat, acc;
    bit to;
    // power 0: 2^0 mod 13 = 1, one cycle
    do_job(13, 0, got, lat, acc, to);
    vectors += 2;
    if (got !== 1 || to) begin
      miscompares++; $display("FAIL pow0_out: got %0d want 1", got);
    end
    if (lat != 1) begin
      miscompares++; $display("FAIL pow0_latency: got %0d want 1", lat);
    end
    // modulus 1 -> 0
    do_job(1, 7, got, lat, acc, to);
    vectors += 2;
    if (got !== 0 || to) begin
      miscompares++; $display("FAIL mod1_out: got %0d want 0", got);
    end
    if (lat != 8) begin
      miscompares++; $display("FAIL mod1_latency: got %0d want 8", lat);
    end
    // modulus 0 -> 0, not an unreduced power of two
    do_job(0, 3, got, lat, acc, to);
    vectors += 2;
    if (got !== 0 || to) begin
      miscompares++; $display("FAIL mod0_out: got %0d want 0", got);
    end
    if (lat != 4) begin
      miscompares++; $display("FAIL mod0_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_max_power();
    logic [MW-1:0] got;
    int lat, acc;
    bit to;
    // 2^1023 mod 13: order of 2 is 12, 1023 mod 12 = 3 -> 8
    do_job(13, 1023, got, lat, acc, to);
    vectors += 3;
    if (got !== 8 || to) begin
      miscompares++; $display("FAIL maxpow_out: got %0d want 8", got);
    end
    if (lat != 1024) begin
      miscompares++; $display("FAIL maxpow_latency: got %0d want 1024", lat);
    end
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL maxpow_i_ready_after: got %b want 1", i_ready);
    end
  endtask

  task automatic test_wide();
    logic [MW-1:0] got;
    logic [MW-1:0] m;
    int lat, acc;
    bit to;
    // N = 2^256 - 189: 2^256 = 189 mod N, so 2^512 = 189^2 = 35721
    m = '1;
    m = m - 188;
    do_job(m, 512, got, lat, acc, to);
    vectors += 2;
    if (got !== 35721 || to) begin
      miscompares++; $display("FAIL wide_out: got %0d want 35721", got);
    end
    if (lat != 513) begin
      miscompares++; $display("FAIL wide_latency: got %0d want 513", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] got_a, got_b;
    int lat_a, lat_b, acc_a, acc_b;
    bit to_a, to_b;
    do_job(13, 3, got_a, lat_a, acc_a, to_a);
    do_job(11, 5, got_b, lat_b, acc_b, to_b);
    vectors += 3;
    if (got_a !== 8 || to_a) begin
      miscompares++; $display("FAIL b2b_first_out: got %0d want 8", got_a);
    end
    if (got_b !== 10 || to_b) begin
      miscompares++; $display("FAIL b2b_second_out: got %0d want 10", got_b);
    end
    // minimum issue interval is power+2 = 5
    if (acc_b - acc_a != 5) begin
      miscompares++; $display("FAIL b2b_interval: got %0d want 5", acc_b - acc_a);
    end
  endtask

  task automatic test_backpressure();
    int waited = 0;
    @(negedge clk);
    i_in.modulus = 13;
    i_in.power   = 4;
    i_valid      = 1'b1;
    o_ready      = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    while (!o_valid && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    vectors++;
    if (!o_valid) begin
      miscompares++; $display("FAIL bp_timeout: got o_valid=%b want 1", o_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_valid      = ~i_valid;
      i_in.modulus = 11 + i;
      i_in.power   = 2;
      @(posedge clk);
      #1;
      vectors += 3;
      if (o_valid !== 1'b1) begin
        miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, o_valid);
      end
      if (o_out !== 3) begin
        miscompares++; $display("FAIL bp_hold_out[%0d]: got %0d want 3", i, o_out);
      end
      if (i_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold_i_ready[%0d]: got %b want 0", i, i_ready);
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors += 2;
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_release_valid: got %b want 0", o_valid);
    end
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release_i_ready: got %b want 1", i_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_no_ghost_job: got o_valid=%b i_ready=%b want 0 1", o_valid, i_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [MW-1:0] got;
    int lat, acc;
    bit to;
    @(negedge clk);
    i_in.modulus = 13;
    i_in.power   = 8;
    i_valid      = 1'b1;
    o_ready      = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (i_ready !== 1'b0) begin
      miscompares++; $display("FAIL abort_busy_i_ready: got %b want 0", i_ready);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors += 3;
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL abort_o_valid: got %b want 0", o_valid);
    end
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL abort_i_ready: got %b want 1", i_ready);
    end
    if (o_out !== '0) begin
      miscompares++; $display("FAIL abort_o_out: got %0d want 0", o_out);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    // 2^5 mod 11 = 32 mod 11 = 10
    do_job(11, 5, got, lat, acc, to);
    vectors += 2;
    if (got !== 10 || to) begin
      miscompares++; $display("FAIL abort_next_out: got %0d want 10", got);
    end
    if (lat != 6) begin
      miscompares++; $display("FAIL abort_next_latency: got %0d want 6", lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_cases();
    test_max_power();
    test_wide();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
